// File: rtl/rgb_pack_arbiter.sv
// rgb_pack_arbiter: round-robin arbiter that shares one byte-to-RGB packer
// between NUM_REQ byte-stream sources. Grants change only on 3-byte pixel
// boundaries. A stalled partial pixel is completed with PAD_BYTE after
// TIMEOUT idle cycles.
//
// Ports
//   sys_clk    clock
//   sys_rst    asynchronous active-high reset, shared with the packer
//   src_valid  per-source byte valid
//   src_data   per-source byte, source i in [8i+7:8i]
//   src_last   per-source end-of-burst, qualified by valid & ready
//   src_ready  per-source accept (combinational from registered state)
//   pk_valid   registered byte valid to the packer
//   pk_data    registered byte to the packer, held while pk_valid is low
//   grant_id   current or last granted source
//   busy       high while a grant is active (XFER or PAD)
//   pad_event  one-cycle pulse on the first PAD cycle
module rgb_pack_arbiter #(
  parameter int unsigned NUM_REQ       = 4,
  parameter int unsigned PIX_PER_GRANT = 16,
  parameter int unsigned TIMEOUT       = 32,
  parameter logic [7:0]  PAD_BYTE      = 8'h00,
  localparam int unsigned GW           = $clog2(NUM_REQ),
  localparam int unsigned PW           = $clog2(PIX_PER_GRANT + 1)
) (
  input  logic                   sys_clk,
  input  logic                   sys_rst,
  input  logic [NUM_REQ-1:0]     src_valid,
  input  logic [8*NUM_REQ-1:0]   src_data,
  input  logic [NUM_REQ-1:0]     src_last,
  output logic [NUM_REQ-1:0]     src_ready,
  output logic                   pk_valid,
  output logic [7:0]             pk_data,
  output logic [GW-1:0]          grant_id,
  output logic                   busy,
  output logic                   pad_event
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    PAD  = 2'd2
  } state_t;

  state_t        state;
  logic [1:0]    byte_idx;
  logic [PW-1:0] pix_cnt;
  logic [7:0]    idle_cnt;
  logic [GW-1:0] rr_ptr;

  logic          any_req;
  logic [GW-1:0] winner;
  logic [GW-1:0] cand;
  logic          sel_valid;
  logic          sel_last;
  logic [7:0]    sel_data;
  logic          xfer;

  // Round-robin pick: nearest requester after rr_ptr; descending scan so the
  // closest candidate is the last one written.
  always_comb begin
    any_req = 1'b0;
    winner  = rr_ptr;
    cand    = '0;
    for (int unsigned k = NUM_REQ; k >= 1; k--) begin
      cand = GW'((32'(rr_ptr) + k) % NUM_REQ);
      if (src_valid[cand]) begin
        any_req = 1'b1;
        winner  = cand;
      end
    end
  end

  // Granted-source mux.
  always_comb begin
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    sel_data  = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (grant_id == GW'(i)) begin
        sel_valid = src_valid[i];
        sel_last  = src_last[i];
        sel_data  = src_data[8*i +: 8];
      end
    end
  end

  // Ready only to the granted source while transferring.
  always_comb begin
    src_ready = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      src_ready[i] = (state == XFER) && (grant_id == GW'(i));
    end
  end

  assign xfer = (state == XFER) && sel_valid;

  // Control FSM with registered outputs.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state     <= IDLE;
      pk_valid  <= 1'b0;
      pk_data   <= '0;
      grant_id  <= '0;
      busy      <= 1'b0;
      pad_event <= 1'b0;
      byte_idx  <= '0;
      pix_cnt   <= '0;
      idle_cnt  <= '0;
      rr_ptr    <= GW'(NUM_REQ - 1);
    end else begin
      pk_valid  <= 1'b0;
      pad_event <= 1'b0;
      case (state)
        IDLE: begin
          if (any_req) begin
            grant_id <= winner;
            rr_ptr   <= winner;
            pix_cnt  <= '0;
            idle_cnt <= '0;
            busy     <= 1'b1;
            state    <= XFER;
          end
        end
        XFER: begin
          if (xfer) begin
            pk_valid <= 1'b1;
            pk_data  <= sel_data;
            idle_cnt <= '0;
            if (byte_idx == 2'd2) begin
              byte_idx <= '0;
              pix_cnt  <= pix_cnt + 1'b1;
              if (sel_last || (pix_cnt == PW'(PIX_PER_GRANT - 1))) begin
                busy  <= 1'b0;
                state <= IDLE;
              end
            end else begin
              byte_idx <= byte_idx + 2'd1;
              if (sel_last) begin
                pad_event <= 1'b1;
                state     <= PAD;
              end
            end
          end else if (idle_cnt == 8'(TIMEOUT - 1)) begin
            // Stall timeout: quiet release on a pixel boundary, else pad out.
            if (byte_idx == 2'd0) begin
              busy  <= 1'b0;
              state <= IDLE;
            end else begin
              pad_event <= 1'b1;
              state     <= PAD;
            end
          end else if (idle_cnt != 8'hFF) begin
            idle_cnt <= idle_cnt + 8'd1;
          end
        end
        PAD: begin
          pk_valid <= 1'b1;
          pk_data  <= PAD_BYTE;
          if (byte_idx == 2'd2) begin
            byte_idx <= '0;
            pix_cnt  <= pix_cnt + 1'b1;
            busy     <= 1'b0;
            state    <= IDLE;
          end else begin
            byte_idx <= byte_idx + 2'd1;
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rgb_pack_arbiter.sv
// Self-checking bench for rgb_pack_arbiter: directed scenarios plus randomized
// multi-source rounds checked against a transaction-level round-robin model.
module tb_rgb_pack_arbiter;

  localparam int unsigned N     = 4;
  localparam int unsigned PPG   = 2;
  localparam int unsigned TO    = 32;
  localparam logic [7:0]  PADB  = 8'hA5;
  localparam int unsigned CAP   = 3 * PPG;
  localparam int unsigned DEPTH = 16;

  logic           sys_clk = 1'b0;
  logic           sys_rst;
  logic [N-1:0]   src_valid;
  logic [8*N-1:0] src_data;
  logic [N-1:0]   src_last;
  logic [N-1:0]   src_ready;
  logic           pk_valid;
  logic [7:0]     pk_data;
  logic [1:0]     grant_id;
  logic           busy;
  logic           pad_event;

  int compared   = 0;
  int mismatched = 0;
  int cyc        = 0;
  int model_ptr  = N - 1;

  // Per-source stimulus: byte, last flag, stall cycles before the byte.
  logic [7:0] sd [N][DEPTH];
  logic       sl [N][DEPTH];
  int         ss [N][DEPTH];
  int         slen [N];
  int         spos [N];

  // Observed packer stream and bench-side transfer log.
  logic [7:0] got_q[$];
  int         got_cyc[$];
  logic       got_busy[$];
  int         pad_ev_cyc[$];
  logic [7:0] xfer_data[$];
  int         xfer_cyc[$];

  rgb_pack_arbiter #(
    .NUM_REQ       (N),
    .PIX_PER_GRANT (PPG),
    .TIMEOUT       (TO),
    .PAD_BYTE      (PADB)
  ) dut (
    .sys_clk   (sys_clk),
    .sys_rst   (sys_rst),
    .src_valid (src_valid),
    .src_data  (src_data),
    .src_last  (src_last),
    .src_ready (src_ready),
    .pk_valid  (pk_valid),
    .pk_data   (pk_data),
    .grant_id  (grant_id),
    .busy      (busy),
    .pad_event (pad_event)
  );

  always #5 sys_clk = ~sys_clk;

  always @(posedge sys_clk) cyc++;

  always @(negedge sys_clk) begin
    if (pk_valid === 1'b1) begin
      got_q.push_back(pk_data);
      got_cyc.push_back(cyc);
      got_busy.push_back(busy);
    end
    if (pad_event === 1'b1) pad_ev_cyc.push_back(cyc);
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic clear_src();
    for (int i = 0; i < N; i++) begin
      slen[i] = 0;
      spos[i] = 0;
      for (int j = 0; j < DEPTH; j++) begin
        sd[i][j] = 8'h00;
        sl[i][j] = 1'b0;
        ss[i][j] = 0;
      end
    end
  endtask

  task automatic load_seq(input int i, input int n, input logic [7:0] base, input bit last);
    slen[i] = n;
    for (int j = 0; j < n; j++) begin
      sd[i][j] = base + 8'(j);
      sl[i][j] = last && (j == n - 1);
      ss[i][j] = 0;
    end
  endtask

  // Present each source's queue, advancing on valid & ready.
  task automatic drive_sources(input int max_cyc, output bit ok);
    int st [N];
    bit xf [N];
    bit active;
    int n;
    ok = 1'b1;
    n  = 0;
    for (int i = 0; i < N; i++) st[i] = 0;
    forever begin
      active = 1'b0;
      for (int i = 0; i < N; i++) begin
        if (spos[i] < slen[i] && st[i] == 0) begin
          src_valid[i]       = 1'b1;
          src_data[8*i +: 8] = sd[i][spos[i]];
          src_last[i]        = sl[i][spos[i]];
        end else begin
          src_valid[i] = 1'b0;
          src_last[i]  = 1'b0;
        end
        if (spos[i] < slen[i]) active = 1'b1;
      end
      if (!active) break;
      if (n >= max_cyc) begin
        ok = 1'b0;
        break;
      end
      @(negedge sys_clk);
      for (int i = 0; i < N; i++) begin
        xf[i] = src_valid[i] && (src_ready[i] === 1'b1);
        if (xf[i]) begin
          xfer_data.push_back(sd[i][spos[i]]);
          xfer_cyc.push_back(cyc);
        end
      end
      @(posedge sys_clk);
      #1;
      for (int i = 0; i < N; i++) begin
        if (xf[i]) begin
          spos[i]++;
          if (spos[i] < slen[i]) st[i] = ss[i][spos[i]];
        end else if (st[i] > 0) begin
          st[i]--;
        end
      end
      n++;
    end
    src_valid = '0;
    src_last  = '0;
  endtask

  task automatic clear_obs();
    got_q.delete();
    got_cyc.delete();
    got_busy.delete();
    pad_ev_cyc.delete();
    xfer_data.delete();
    xfer_cyc.delete();
  endtask

  // Drive the loaded queues, then wait (bounded) for the grant to finish.
  task automatic drive_and_settle(input string name);
    bit ok;
    int n;
    for (int i = 0; i < N; i++) spos[i] = 0;
    drive_sources(4000, ok);
    compared++;
    if (!ok) begin
      mismatched++;
      $display("FAIL %s drive: sources not drained, remaining budget 0", name);
    end
    n = 0;
    @(negedge sys_clk);
    while (busy !== 1'b0 && n < 200) begin
      @(negedge sys_clk);
      n++;
    end
    compared++;
    if (busy !== 1'b0) begin
      mismatched++;
      $display("FAIL %s settle: busy=%b required 0", name, busy);
    end
    repeat (3) @(negedge sys_clk);
  endtask

  // Each loaded source (all requesting at once, n <= CAP) gets one grant in
  // circular order after model_ptr; a grant carries its bytes plus pad bytes
  // up to the next multiple of 3.
  task automatic run_trial(input string name);
    logic [7:0] exp_q[$];
    int  exp_pads;
    int  last_w;
    int  w;
    int  pads;
    bit  found;
    exp_pads = 0;
    last_w   = -1;
    clear_obs();
    for (int s = 1; s <= N; s++) begin
      w = (model_ptr + s) % N;
      if (slen[w] > 0) begin
        for (int j = 0; j < slen[w]; j++) exp_q.push_back(sd[w][j]);
        pads = (3 - (slen[w] % 3)) % 3;
        for (int p = 0; p < pads; p++) exp_q.push_back(PADB);
        if (pads > 0) exp_pads++;
        last_w = w;
      end
    end
    drive_and_settle(name);
    compared++;
    if (got_q.size() != exp_q.size()) begin
      mismatched++;
      $display("FAIL %s beat_count: got %0d required %0d", name, got_q.size(), exp_q.size());
    end
    for (int k = 0; k < exp_q.size() && k < got_q.size(); k++) begin
      compared++;
      if (got_q[k] !== exp_q[k]) begin
        mismatched++;
        $display("FAIL %s beat[%0d]: got %02h required %02h", name, k, got_q[k], exp_q[k]);
      end
    end
    for (int k = 0; k < xfer_cyc.size(); k++) begin
      found = 1'b0;
      for (int m = 0; m < got_cyc.size(); m++) begin
        if (got_cyc[m] == xfer_cyc[k] + 1 && got_q[m] === xfer_data[k]) found = 1'b1;
      end
      compared++;
      if (!found) begin
        mismatched++;
        $display("FAIL %s latency[%0d]: byte %02h not seen at cycle %0d", name, k, xfer_data[k], xfer_cyc[k] + 1);
      end
    end
    compared++;
    if (pad_ev_cyc.size() != exp_pads) begin
      mismatched++;
      $display("FAIL %s pad_events: got %0d required %0d", name, pad_ev_cyc.size(), exp_pads);
    end
    if (last_w >= 0) begin
      compared++;
      if (grant_id !== 2'(last_w)) begin
        mismatched++;
        $display("FAIL %s grant_id: got %0d required %0d", name, grant_id, last_w);
      end
      model_ptr = last_w;
    end
  endtask

  task automatic test_reset();
    sys_rst   = 1'b1;
    src_valid = '1;
    src_last  = '0;
    src_data  = 32'hDEADBEEF;
    repeat (2) @(negedge sys_clk);
    compared += 6;
    if (pk_valid !== 1'b0)  begin mismatched++; $display("FAIL reset pk_valid: got %b required 0", pk_valid); end
    if (pk_data !== 8'h00)  begin mismatched++; $display("FAIL reset pk_data: got %02h required 00", pk_data); end
    if (grant_id !== 2'd0)  begin mismatched++; $display("FAIL reset grant_id: got %0d required 0", grant_id); end
    if (busy !== 1'b0)      begin mismatched++; $display("FAIL reset busy: got %b required 0", busy); end
    if (pad_event !== 1'b0) begin mismatched++; $display("FAIL reset pad_event: got %b required 0", pad_event); end
    if (src_ready !== 4'b0) begin mismatched++; $display("FAIL reset src_ready: got %b required 0000", src_ready); end
    src_valid = '0;
    sys_rst   = 1'b0;
    model_ptr = N - 1;
    repeat (2) @(negedge sys_clk);
    compared++;
    if (busy !== 1'b0) begin mismatched++; $display("FAIL reset idle_busy: got %b required 0", busy); end
  endtask

  task automatic test_single();
    clear_src();
    load_seq(0, 6, 8'h11, 1'b1);
    run_trial("single");
    compared++;
    if (got_busy.size() < 6 || got_busy[4] !== 1'b1 || got_busy[5] !== 1'b0) begin
      mismatched++;
      $display("FAIL single busy_fall: beats %0d, busy at beats 5/6 not 1/0", got_busy.size());
    end
  endtask

  task automatic test_pix_grant();
    logic [7:0] exp_q[$];
    clear_src();
    clear_obs();
    load_seq(0, 12, 8'h01, 1'b0);
    load_seq(2, 12, 8'h21, 1'b0);
    for (int j = 0; j < 6; j++) exp_q.push_back(8'h01 + 8'(j));
    for (int j = 0; j < 6; j++) exp_q.push_back(8'h21 + 8'(j));
    for (int j = 6; j < 12; j++) exp_q.push_back(8'h01 + 8'(j));
    for (int j = 6; j < 12; j++) exp_q.push_back(8'h21 + 8'(j));
    drive_and_settle("pix_grant");
    compared++;
    if (got_q.size() != 24) begin
      mismatched++;
      $display("FAIL pix_grant beat_count: got %0d required 24", got_q.size());
    end
    for (int k = 0; k < 24 && k < got_q.size(); k++) begin
      compared++;
      if (got_q[k] !== exp_q[k]) begin
        mismatched++;
        $display("FAIL pix_grant beat[%0d]: got %02h required %02h", k, got_q[k], exp_q[k]);
      end
    end
    compared++;
    if (got_cyc.size() < 7 || got_cyc[6] - got_cyc[5] != 2) begin
      mismatched++;
      $display("FAIL pix_grant idle_gap: beat gap not 2 cycles (beats %0d)", got_cyc.size());
    end
    compared++;
    if (pad_ev_cyc.size() != 0) begin
      mismatched++;
      $display("FAIL pix_grant pad_events: got %0d required 0", pad_ev_cyc.size());
    end
    model_ptr = 2;
  endtask

  task automatic test_timeout_pad();
    int xl;
    clear_src();
    load_seq(1, 4, 8'h41, 1'b0);
    run_trial("timeout_pad");
    xl = (xfer_cyc.size() > 0) ? xfer_cyc[xfer_cyc.size() - 1] : 0;
    compared++;
    if (pad_ev_cyc.size() < 1 || pad_ev_cyc[0] != xl + TO + 1) begin
      mismatched++;
      $display("FAIL timeout_pad pad_cycle: got %0d required %0d",
               (pad_ev_cyc.size() > 0) ? pad_ev_cyc[0] - xl : -1, TO + 1);
    end
    compared++;
    if (got_cyc.size() < 6 || got_cyc[5] != xl + TO + 3) begin
      mismatched++;
      $display("FAIL timeout_pad last_pad_cycle: beats %0d, final beat not at +%0d", got_cyc.size(), TO + 3);
    end
  endtask

  task automatic test_last_pad();
    int xl;
    clear_src();
    load_seq(3, 5, 8'h61, 1'b1);
    run_trial("last_pad");
    xl = (xfer_cyc.size() > 0) ? xfer_cyc[xfer_cyc.size() - 1] : 0;
    compared++;
    if (pad_ev_cyc.size() < 1 || pad_ev_cyc[0] != xl + 1) begin
      mismatched++;
      $display("FAIL last_pad pad_cycle: pad_event not on cycle after last byte");
    end
    compared++;
    if (got_cyc.size() < 6 || got_cyc[5] != xl + 2) begin
      mismatched++;
      $display("FAIL last_pad pad_beat_cycle: pad beat not back-to-back with last byte");
    end
  endtask

  task automatic test_boundary_release();
    clear_src();
    load_seq(0, 3, 8'h81, 1'b0);
    run_trial("boundary_release");
  endtask

  task automatic test_stall_boundary();
    clear_src();
    load_seq(2, 6, 8'hC1, 1'b1);
    ss[2][3] = TO - 1;
    run_trial("stall_boundary");
  endtask

  task automatic test_reset_mid();
    int n;
    src_valid          = 4'b0001;
    src_data[7:0]      = 8'h77;
    src_last           = '0;
    n = 0;
    @(negedge sys_clk);
    while (src_ready[0] !== 1'b1 && n < 10) begin
      @(negedge sys_clk);
      n++;
    end
    @(negedge sys_clk);
    compared++;
    if (pk_valid !== 1'b1) begin mismatched++; $display("FAIL reset_mid pre_valid: got %b required 1", pk_valid); end
    sys_rst = 1'b1;
    #1;
    compared += 4;
    if (pk_valid !== 1'b0)  begin mismatched++; $display("FAIL reset_mid pk_valid: got %b required 0", pk_valid); end
    if (src_ready !== 4'b0) begin mismatched++; $display("FAIL reset_mid src_ready: got %b required 0000", src_ready); end
    if (busy !== 1'b0)      begin mismatched++; $display("FAIL reset_mid busy: got %b required 0", busy); end
    if (pk_data !== 8'h00)  begin mismatched++; $display("FAIL reset_mid pk_data: got %02h required 00", pk_data); end
    src_valid = '0;
    @(negedge sys_clk);
    sys_rst   = 1'b0;
    model_ptr = N - 1;
    @(negedge sys_clk);
    clear_src();
    for (int i = 0; i < N; i++) load_seq(i, 3, 8'h10 * 8'(i + 1), 1'b0);
    run_trial("after_reset");
  endtask

  task automatic test_random(input int trials);
    logic [N-1:0] req;
    int r;
    for (int t = 0; t < trials; t++) begin
      clear_src();
      req = N'($urandom_range(1, (1 << N) - 1));
      for (int i = 0; i < N; i++) begin
        if (req[i]) begin
          slen[i] = $urandom_range(1, CAP);
          for (int j = 0; j < slen[i]; j++) begin
            sd[i][j] = 8'($urandom);
            sl[i][j] = (j == slen[i] - 1) ? 1'($urandom_range(0, 1)) : 1'b0;
            r = $urandom_range(0, 9);
            ss[i][j] = (j == 0 || r < 7) ? 0 : ((r == 9) ? TO - 1 : $urandom_range(1, 4));
          end
        end
      end
      run_trial($sformatf("random%0d", t));
    end
  endtask

  initial begin
    sys_rst   = 1'b1;
    src_valid = '0;
    src_last  = '0;
    src_data  = '0;
    clear_src();
    test_reset();
    test_pix_grant();
    test_single();
    test_timeout_pad();
    test_last_pad();
    test_boundary_release();
    test_stall_boundary();
    test_reset_mid();
    test_random(30);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
